// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  // RISC-V funct3 codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Data-memory size codes
  localparam logic [2:0] MSZ_WORD = 3'b000;
  localparam logic [2:0] MSZ_HALF = 3'b001;
  localparam logic [2:0] MSZ_BYTE = 3'b010;

  // The low two funct3 bits carry the access width for both signed and unsigned forms
  function automatic logic [2:0] f3_to_msize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MSZ_BYTE;
      2'b01:   return MSZ_HALF;
      default: return MSZ_WORD;
    endcase
  endfunction

  // Unsigned variants only exist for loads
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  // Bytes are always aligned; halves need bit 0 clear, words need bits 1:0 clear
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of right-justified load data according to funct3.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  // Pick the extension matching the load flavour; words pass straight through
  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
      F3_BU:   ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
      F3_H:    ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      F3_HU:   ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, single-cycle memory strobe,
// fixed read latency, extended load data returned over a valid/ready handshake.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic              accept;
  logic              req_bad;
  logic              load_done;
  logic [DATA_W-1:0] ext_data;

  assign accept    = (state == IDLE) && req_valid;
  assign req_bad   = !f3_legal(req_we, req_funct3) || addr_misaligned(req_funct3, req_addr[1:0]);
  assign load_done = (state == WAIT) && (cnt <= 3'd1);

  lsu_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .funct3(cap_f3),
    .raw   (mem_rdata),
    .ext   (ext_data)
  );

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the state-decoded handshake and strobe outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_read   = !cap_we;
        mem_write  = cap_we;
        state_next = cap_we ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt <= 3'd1) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read latency counter, loaded as the read strobe goes out
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cnt <= 3'd0;
    else if (state == ISSUE)             cnt <= LAT_INIT;
    else if (state == WAIT && cnt != 0)  cnt <= cnt - 3'd1;
  end

  // Capture the request; memory-side fields only change for accesses that will be issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_f3    <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= MSZ_WORD;
    end else if (accept) begin
      cap_we <= req_we;
      cap_f3 <= req_funct3;
      if (!req_bad) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        mem_size  <= f3_to_msize(req_funct3);
      end
    end
  end

  // Response registers: cleared on accept, filled with extended data when the load returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_err   <= req_bad;
    end else if (load_done) begin
      resp_rdata <= ext_data;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: two instances (read latency 1 and 3)
// sharing request inputs, with a latency-accurate memory model per instance.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_ready = 1'b0;
  int          sel = 0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // per-instance handshake gating
  logic req_valid_l1, req_valid_l3, resp_ready_l1, resp_ready_l3;
  assign req_valid_l1  = req_valid  && (sel == 0);
  assign req_valid_l3  = req_valid  && (sel == 1);
  assign resp_ready_l1 = resp_ready && (sel == 0);
  assign resp_ready_l3 = resp_ready && (sel == 1);

  logic        req_ready_l1, resp_valid_l1, resp_err_l1, mem_read_l1, mem_write_l1;
  logic [31:0] resp_rdata_l1, mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
  logic [2:0]  mem_size_l1;
  logic        req_ready_l3, resp_valid_l3, resp_err_l3, mem_read_l3, mem_write_l3;
  logic [31:0] resp_rdata_l3, mem_addr_l3, mem_wdata_l3, mem_rdata_l3;
  logic [2:0]  mem_size_l3;

  lsu_ctrl #(.READ_LAT(1), .ADDR_W(32), .DATA_W(32)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_l1), .resp_ready(resp_ready_l1),
    .resp_rdata(resp_rdata_l1), .resp_err(resp_err_l1),
    .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1), .mem_read(mem_read_l1),
    .mem_write(mem_write_l1), .mem_size(mem_size_l1), .mem_rdata(mem_rdata_l1)
  );

  lsu_ctrl #(.READ_LAT(3), .ADDR_W(32), .DATA_W(32)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_l3), .req_ready(req_ready_l3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_l3), .resp_ready(resp_ready_l3),
    .resp_rdata(resp_rdata_l3), .resp_err(resp_err_l3),
    .mem_addr(mem_addr_l3), .mem_wdata(mem_wdata_l3), .mem_read(mem_read_l3),
    .mem_write(mem_write_l3), .mem_size(mem_size_l3), .mem_rdata(mem_rdata_l3)
  );

  // observed view of the selected instance
  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_read, o_mem_write;
  logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
  logic [2:0]  o_mem_size;
  assign o_req_ready  = (sel == 0) ? req_ready_l1  : req_ready_l3;
  assign o_resp_valid = (sel == 0) ? resp_valid_l1 : resp_valid_l3;
  assign o_resp_err   = (sel == 0) ? resp_err_l1   : resp_err_l3;
  assign o_resp_rdata = (sel == 0) ? resp_rdata_l1 : resp_rdata_l3;
  assign o_mem_read   = (sel == 0) ? mem_read_l1   : mem_read_l3;
  assign o_mem_write  = (sel == 0) ? mem_write_l1  : mem_write_l3;
  assign o_mem_addr   = (sel == 0) ? mem_addr_l1   : mem_addr_l3;
  assign o_mem_wdata  = (sel == 0) ? mem_wdata_l1  : mem_wdata_l3;
  assign o_mem_size   = (sel == 0) ? mem_size_l1   : mem_size_l3;

  // memory models: data is valid only in the single cycle READ_LAT cycles after the strobe edge
  logic [31:0] mem_data = 32'h0;
  int cd1 = 0;
  int cd3 = 0;
  always @(posedge clk) begin
    if (mem_read_l1)   cd1 <= 1;
    else if (cd1 > 0)  cd1 <= cd1 - 1;
    if (mem_read_l3)   cd3 <= 3;
    else if (cd3 > 0)  cd3 <= cd3 - 1;
  end
  assign mem_rdata_l1 = (cd1 == 1) ? mem_data : ~mem_data;
  assign mem_rdata_l3 = (cd3 == 1) ? mem_data : ~mem_data;

  // ---------------- reference model ----------------
  function automatic int model_bytes(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit model_err(input bit we, input int f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    if (!legal) return 1'b1;
    return (a % 32'(model_bytes(f3))) != 0;
  endfunction

  function automatic logic [2:0] model_size(input int f3);
    case (model_bytes(f3))
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] d);
    int     bits;
    longint v;
    bits = 8 * model_bytes(f3);
    if (bits >= 32) return d;
    v = longint'(d) % (longint'(1) << bits);
    if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  function automatic int model_rl();
    return (sel == 0) ? 1 : 3;
  endfunction

  // ---------------- transaction driver (records observations only) ----------------
  int          lat, nrd, nwr;
  logic [31:0] s_addr, s_wdata, r_rdata;
  logic [2:0]  s_size;
  logic        r_err, pre_ready, post_valid, post_ready;
  bit          stable;

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] md,
                         input int hold, input bit spam);
    mem_data   = md;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    pre_ready  = o_req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0;
    s_addr = 'x; s_wdata = 'x; s_size = 'x; r_rdata = 'x; r_err = 'x;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (o_mem_read === 1'b1 || o_mem_write === 1'b1) begin
        if (o_mem_read === 1'b1) nrd++;
        if (o_mem_write === 1'b1) nwr++;
        s_addr = o_mem_addr; s_size = o_mem_size; s_wdata = o_mem_wdata;
      end
      if (o_resp_valid === 1'b1) begin
        lat = c; r_rdata = o_resp_rdata; r_err = o_resp_err;
      end else begin
        @(negedge clk);
      end
    end
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (spam) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0100; req_wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (o_resp_valid !== 1'b1 || o_resp_rdata !== r_rdata || o_resp_err !== r_err ||
          o_req_ready !== 1'b0 || o_mem_read !== 1'b0 || o_mem_write !== 1'b0)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    post_valid = o_resp_valid;
    post_ready = o_req_ready;
    req_valid  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready_l1, resp_valid_l1, resp_err_l1, mem_read_l1, mem_write_l1, mem_size_l1} !== 8'b1000_0000)
      $display("[TB] FAIL reset_ctrl_l1: got %b expected 10000000",
               {req_ready_l1, resp_valid_l1, resp_err_l1, mem_read_l1, mem_write_l1, mem_size_l1});
    else passed++;
    checks++;
    if ({resp_rdata_l1, mem_addr_l1, mem_wdata_l1} !== 96'h0)
      $display("[TB] FAIL reset_buses_l1: got %h expected 0", {resp_rdata_l1, mem_addr_l1, mem_wdata_l1});
    else passed++;
    checks++;
    if ({req_ready_l3, resp_valid_l3, resp_err_l3, mem_read_l3, mem_write_l3, mem_size_l3} !== 8'b1000_0000)
      $display("[TB] FAIL reset_ctrl_l3: got %b expected 10000000",
               {req_ready_l3, resp_valid_l3, resp_err_l3, mem_read_l3, mem_write_l3, mem_size_l3});
    else passed++;
    checks++;
    if ({resp_rdata_l3, mem_addr_l3, mem_wdata_l3} !== 96'h0)
      $display("[TB] FAIL reset_buses_l3: got %h expected 0", {resp_rdata_l3, mem_addr_l3, mem_wdata_l3});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    sel = 0;
    run_txn(1'b1, 3'b010, 32'h000A_0004, 32'h1111_1111, $urandom, 0, 1'b0);
    checks++;
    if (pre_ready !== 1'b1) $display("[TB] FAIL sw_req_ready: got %b expected 1", pre_ready); else passed++;
    checks++;
    if (lat !== 2) $display("[TB] FAIL sw_latency: got %0d expected 2", lat); else passed++;
    checks++;
    if (nwr !== 1 || nrd !== 0) $display("[TB] FAIL sw_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", nwr, nrd); else passed++;
    checks++;
    if ({s_addr, s_wdata, s_size} !== {32'h000A_0004, 32'h1111_1111, 3'b000})
      $display("[TB] FAIL sw_mem_fields: got addr=%h wdata=%h size=%b expected 000a0004 11111111 000", s_addr, s_wdata, s_size);
    else passed++;
    checks++;
    if (r_rdata !== 32'h0 || r_err !== 1'b0) $display("[TB] FAIL sw_resp: got rdata=%h err=%b expected 0 0", r_rdata, r_err); else passed++;
    checks++;
    if (post_valid !== 1'b0 || post_ready !== 1'b1)
      $display("[TB] FAIL sw_after_hs: got valid=%b ready=%b expected 0 1", post_valid, post_ready);
    else passed++;
  endtask

  task automatic test_byte_loads();
    logic [2:0]  f3s [2]  = '{3'b000, 3'b100};
    logic [31:0] exps [2] = '{32'hFFFF_FFF3, 32'h0000_00F3};
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, f3s[i], 32'h000A_0013, $urandom, 32'h0000_00F3, 0, 1'b0);
      checks++;
      if (lat !== 3) $display("[TB] FAIL byte_latency[%0d]: got %0d expected 3", i, lat); else passed++;
      checks++;
      if (nrd !== 1 || nwr !== 0 || s_size !== 3'b010 || s_addr !== 32'h000A_0013)
        $display("[TB] FAIL byte_mem[%0d]: got rd=%0d wr=%0d size=%b addr=%h expected 1 0 010 000a0013", i, nrd, nwr, s_size, s_addr);
      else passed++;
      checks++;
      if (r_rdata !== exps[i] || r_err !== 1'b0)
        $display("[TB] FAIL byte_data[%0d]: got %h err=%b expected %h err=0", i, r_rdata, r_err, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_half_loads();
    logic [2:0]  f3s [2]  = '{3'b001, 3'b101};
    logic [31:0] exps [2] = '{32'hFFFF_8222, 32'h0000_8222};
    sel = 1;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, f3s[i], 32'h000A_0012, $urandom, 32'h0000_8222, 0, 1'b0);
      checks++;
      if (lat !== 5) $display("[TB] FAIL half_latency[%0d]: got %0d expected 5", i, lat); else passed++;
      checks++;
      if (nrd !== 1 || nwr !== 0 || s_size !== 3'b001)
        $display("[TB] FAIL half_mem[%0d]: got rd=%0d wr=%0d size=%b expected 1 0 001", i, nrd, nwr, s_size);
      else passed++;
      checks++;
      if (r_rdata !== exps[i]) $display("[TB] FAIL half_data[%0d]: got %h expected %h", i, r_rdata, exps[i]); else passed++;
    end
  endtask

  task automatic test_errors();
    logic        wes  [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b100};
    logic [31:0] adrs [3] = '{32'h000A_0006, 32'h000A_0009, 32'h000A_0000};
    for (int i = 0; i < 3; i++) begin
      sel = i % 2;
      run_txn(wes[i], f3s[i], adrs[i], $urandom, 32'h5A5A_F0F0, 0, 1'b0);
      checks++;
      if (lat !== 1) $display("[TB] FAIL err_latency[%0d]: got %0d expected 1", i, lat); else passed++;
      checks++;
      if (r_err !== 1'b1 || r_rdata !== 32'h0)
        $display("[TB] FAIL err_resp[%0d]: got err=%b rdata=%h expected 1 0", i, r_err, r_rdata);
      else passed++;
      checks++;
      if (nrd !== 0 || nwr !== 0) $display("[TB] FAIL err_strobes[%0d]: got rd=%0d wr=%0d expected 0 0", i, nrd, nwr); else passed++;
    end
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_txn(1'b0, 3'b010, 32'h000A_0008, $urandom, 32'h2222_2222, 4, 1'b1);
    checks++;
    if (lat !== 3 || r_rdata !== 32'h2222_2222)
      $display("[TB] FAIL bp_resp: got lat=%0d rdata=%h expected 3 22222222", lat, r_rdata);
    else passed++;
    checks++;
    if (stable !== 1'b1) $display("[TB] FAIL bp_stable: got %b expected 1", stable); else passed++;
    checks++;
    if (post_valid !== 1'b0 || post_ready !== 1'b1)
      $display("[TB] FAIL bp_no_bypass: got valid=%b ready=%b expected 0 1", post_valid, post_ready);
    else passed++;
    run_txn(1'b0, 3'b010, 32'h000A_000C, $urandom, 32'h4444_4444, 0, 1'b0);
    checks++;
    if (lat !== 3 || r_rdata !== 32'h4444_4444)
      $display("[TB] FAIL bp_next: got lat=%0d rdata=%h expected 3 44444444", lat, r_rdata);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    bit leaked;
    sel = 1;
    // abort during WAIT
    mem_data = 32'h3333_3333;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h000A_0010; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (o_mem_read !== 1'b1) $display("[TB] FAIL rst_issue_strobe: got %b expected 1", o_mem_read); else passed++;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_mem_read, o_resp_valid, o_req_ready} !== 3'b001 || o_mem_addr !== 32'h0)
      $display("[TB] FAIL rst_wait_abort: got rd/valid/ready=%b addr=%h expected 001 0",
               {o_mem_read, o_resp_valid, o_req_ready}, o_mem_addr);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    leaked = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_mem_read !== 1'b0) leaked = 1'b1;
    end
    checks++;
    if (leaked) $display("[TB] FAIL rst_no_response: got leak=1 expected 0"); else passed++;
    // abort while the read strobe is up
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_mem_read !== 1'b0 || o_req_ready !== 1'b1)
      $display("[TB] FAIL rst_issue_abort: got rd=%b ready=%b expected 0 1", o_mem_read, o_req_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 3'b010, 32'h000A_0014, $urandom, 32'h7777_1234, 0, 1'b0);
    checks++;
    if (lat !== 5 || r_rdata !== 32'h7777_1234 || nrd !== 1)
      $display("[TB] FAIL rst_recover: got lat=%0d rdata=%h rd=%0d expected 5 77771234 1", lat, r_rdata, nrd);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          we, e;
      int          f3, xlat;
      logic [31:0] a, wd, md, xr;
      sel = $urandom_range(0, 1);
      we  = 1'($urandom_range(0, 1));
      f3  = $urandom_range(0, 7);
      a   = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & 32'hFFFF_FFFC;
      wd  = $urandom;
      md  = $urandom;
      e    = model_err(we, f3, a);
      xlat = e ? 1 : (we ? 2 : model_rl() + 2);
      xr   = (e || we) ? 32'h0 : model_load(f3, md);
      run_txn(we, 3'(f3), a, wd, md, $urandom_range(0, 2), 1'b0);
      checks++;
      if (lat !== xlat || r_err !== e || r_rdata !== xr)
        $display("[TB] FAIL rand[%0d]: got lat=%0d err=%b rdata=%h expected %0d %b %h (we=%b f3=%0d a=%h)",
                 i, lat, r_err, r_rdata, xlat, e, xr, we, f3, a);
      else passed++;
      checks++;
      if (nrd + nwr !== (e ? 0 : 1) || (!e && (s_addr !== a || s_size !== model_size(f3))))
        $display("[TB] FAIL rand_mem[%0d]: got strobes=%0d addr=%h size=%b expected %0d %h %b",
                 i, nrd + nwr, s_addr, s_size, e ? 0 : 1, a, model_size(f3));
      else passed++;
      checks++;
      if (!e && we && s_wdata !== wd) $display("[TB] FAIL rand_wdata[%0d]: got %h expected %h", i, s_wdata, wd);
      else passed++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_word();
    test_byte_loads();
    test_half_loads();
    test_errors();
    test_backpressure();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
